// File: rtl/machine_input_filter.sv
// rtl/machine_input_filter.sv - input conditioning for motor-error and fail-sensor lines
//
// Purpose: synchronise, debounce and optionally latch raw board fault lines
// before they reach the machine control logic.
//
// Ports:
//   CLK            in   system clock, rising edge
//   RSTn           in   asynchronous active-low reset
//   MOT_ERR_RAW    in   [N_MOT]  raw motor error pins, 1 = error, async to CLK
//   FAIL_SENS_RAWn in   [N_SENS] raw fail sensor pins, 0 = fail, async to CLK
//   ERR_CLR        in   single-cycle pulse clearing latched faults
//   MOT_ERR        out  [N_MOT]  conditioned motor errors, 1 = error
//   FAIL_SENSn     out  [N_SENS] conditioned fail sensors, 0 = fail
//   FAULT_ANY      out  registered OR of all conditioned faults
//   FAULT_NEW      out  one-cycle strobe when any output newly enters fault
module machine_input_filter #(
    parameter int N_MOT           = 5,
    parameter int N_SENS          = 3,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STICKY          = 1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [N_MOT-1:0]  MOT_ERR_RAW,
    input  logic [N_SENS-1:0] FAIL_SENS_RAWn,
    input  logic              ERR_CLR,
    output logic [N_MOT-1:0]  MOT_ERR,
    output logic [N_SENS-1:0] FAIL_SENSn,
    output logic              FAULT_ANY,
    output logic              FAULT_NEW
);

    localparam int N  = N_MOT + N_SENS;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Every channel is handled in fault polarity (1 = fault) so that the
    // reset value 0 is the inactive level for motor and sensor lines alike.
    logic [N-1:0] raw_fault;
    assign raw_fault = {~FAIL_SENS_RAWn, MOT_ERR_RAW};

    logic [N-1:0]  sync1_q, sync1_d;
    logic [N-1:0]  sync2_q, sync2_d;
    logic [N-1:0]  deb_q, deb_d;
    logic [N-1:0]  lat_q, lat_d;
    logic [N-1:0]  out_q, out_d;
    logic [N-1:0]  out_prev_q, out_prev_d;
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];
    logic          fault_any_q, fault_any_d;
    logic          fault_new_q, fault_new_d;

    always_comb begin
        sync1_d = raw_fault;
        sync2_d = sync1_q;

        deb_d = deb_q;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                // Toggle on the edge where the count has already seen
                // DEBOUNCE_CYCLES-1 differing samples and the input still differs.
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end

        // An active debounced level keeps setting the latch, so a set always
        // beats a simultaneous clear and a clear only affects idle channels.
        if (STICKY != 0) begin
            lat_d = deb_q | (lat_q & {N{~ERR_CLR}});
        end else begin
            lat_d = '0;
        end

        out_d       = deb_q | lat_q;
        out_prev_d  = out_q;
        fault_any_d = |out_q;
        fault_new_d = |(out_q & ~out_prev_q);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            lat_q       <= '0;
            out_q       <= '0;
            out_prev_q  <= '0;
            fault_any_q <= 1'b0;
            fault_new_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_q       <= deb_d;
            lat_q       <= lat_d;
            out_q       <= out_d;
            out_prev_q  <= out_prev_d;
            fault_any_q <= fault_any_d;
            fault_new_q <= fault_new_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign MOT_ERR    = out_q[N_MOT-1:0];
    assign FAIL_SENSn = ~out_q[N-1:N_MOT];
    assign FAULT_ANY  = fault_any_q;
    assign FAULT_NEW  = fault_new_q;

endmodule

// File: tb/tb_machine_input_filter.sv
// tb/tb_machine_input_filter.sv - directed self-checking bench for machine_input_filter
module tb_machine_input_filter;

    logic       clk;
    logic       rst_n;
    logic [4:0] mot_raw;
    logic [2:0] sens_raw_n;
    logic       err_clr;
    logic [4:0] mot_err;
    logic [2:0] fail_sens_n;
    logic       fault_any;
    logic       fault_new;

    int total;
    int bad;

    machine_input_filter #(
        .N_MOT(5),
        .N_SENS(3),
        .DEBOUNCE_CYCLES(4),
        .STICKY(1)
    ) dut (
        .CLK(clk),
        .RSTn(rst_n),
        .MOT_ERR_RAW(mot_raw),
        .FAIL_SENS_RAWn(sens_raw_n),
        .ERR_CLR(err_clr),
        .MOT_ERR(mot_err),
        .FAIL_SENSn(fail_sens_n),
        .FAULT_ANY(fault_any),
        .FAULT_NEW(fault_new)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        mot_raw    = 5'b00000;
        sens_raw_n = 3'b111;
        err_clr    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (mot_err !== 5'b00000) begin
            bad++;
            $display("FAIL rst_mot_during got=%b exp=00000", mot_err);
        end
        total++;
        if (fail_sens_n !== 3'b111) begin
            bad++;
            $display("FAIL rst_sens_during got=%b exp=111", fail_sens_n);
        end
        total++;
        if (fault_any !== 1'b0) begin
            bad++;
            $display("FAIL rst_any_during got=%b exp=0", fault_any);
        end
        rst_n = 1'b1;
        repeat (4) tick();
        total++;
        if (mot_err !== 5'b00000 || fail_sens_n !== 3'b111) begin
            bad++;
            $display("FAIL rst_after got=%b/%b exp=00000/111", mot_err, fail_sens_n);
        end
        total++;
        if (fault_any !== 1'b0 || fault_new !== 1'b0) begin
            bad++;
            $display("FAIL rst_flags_after got=%b%b exp=00", fault_any, fault_new);
        end
    endtask

    task automatic test_mot_latency();
        mot_raw = 5'b00001;
        repeat (6) tick();
        total++;
        if (mot_err !== 5'b00000) begin
            bad++;
            $display("FAIL mot_lat_early got=%b exp=00000", mot_err);
        end
        tick();
        total++;
        if (mot_err !== 5'b00001) begin
            bad++;
            $display("FAIL mot_lat_exact got=%b exp=00001", mot_err);
        end
        total++;
        if (fault_any !== 1'b0 || fault_new !== 1'b0) begin
            bad++;
            $display("FAIL mot_flags_early got=%b%b exp=00", fault_any, fault_new);
        end
        tick();
        total++;
        if (fault_any !== 1'b1 || fault_new !== 1'b1) begin
            bad++;
            $display("FAIL mot_flags_set got=%b%b exp=11", fault_any, fault_new);
        end
        tick();
        total++;
        if (fault_new !== 1'b0) begin
            bad++;
            $display("FAIL mot_new_single got=%b exp=0", fault_new);
        end
        tick();
        mot_raw = 5'b00000;
        repeat (8) tick();
        total++;
        if (mot_err !== 5'b00001) begin
            bad++;
            $display("FAIL mot_sticky got=%b exp=00001", mot_err);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
        total++;
        if (mot_err !== 5'b00000) begin
            bad++;
            $display("FAIL mot_cleared got=%b exp=00000", mot_err);
        end
        tick();
        total++;
        if (fault_any !== 1'b0) begin
            bad++;
            $display("FAIL mot_any_cleared got=%b exp=0", fault_any);
        end
    endtask

    task automatic test_glitch();
        logic seen;
        seen    = 1'b0;
        mot_raw = 5'b00100;
        repeat (3) tick();
        mot_raw = 5'b00000;
        repeat (10) begin
            tick();
            if (mot_err !== 5'b00000 || fault_new !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL glitch_blocked got=%b exp=0", seen);
        end
    endtask

    task automatic test_sens_latch();
        sens_raw_n = 3'b110;
        repeat (6) tick();
        total++;
        if (fail_sens_n !== 3'b111) begin
            bad++;
            $display("FAIL sens_lat_early got=%b exp=111", fail_sens_n);
        end
        tick();
        total++;
        if (fail_sens_n !== 3'b110) begin
            bad++;
            $display("FAIL sens_lat_exact got=%b exp=110", fail_sens_n);
        end
        tick();
        total++;
        if (fault_new !== 1'b1) begin
            bad++;
            $display("FAIL sens_new got=%b exp=1", fault_new);
        end
        repeat (2) tick();
        sens_raw_n = 3'b111;
        repeat (10) tick();
        total++;
        if (fail_sens_n !== 3'b110 || fault_any !== 1'b1) begin
            bad++;
            $display("FAIL sens_sticky got=%b/%b exp=110/1", fail_sens_n, fault_any);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
        total++;
        if (fail_sens_n !== 3'b111) begin
            bad++;
            $display("FAIL sens_cleared got=%b exp=111", fail_sens_n);
        end
        tick();
        total++;
        if (fault_any !== 1'b0) begin
            bad++;
            $display("FAIL sens_any_cleared got=%b exp=0", fault_any);
        end
    endtask

    task automatic test_clr_while_held();
        mot_raw = 5'b00001;
        repeat (8) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        repeat (3) tick();
        total++;
        if (mot_err !== 5'b00001) begin
            bad++;
            $display("FAIL held_clr_ignored got=%b exp=00001", mot_err);
        end
        total++;
        if (fault_new !== 1'b0) begin
            bad++;
            $display("FAIL held_no_new got=%b exp=0", fault_new);
        end
        mot_raw = 5'b00000;
        repeat (8) tick();
        total++;
        if (mot_err !== 5'b00001) begin
            bad++;
            $display("FAIL held_sticky got=%b exp=00001", mot_err);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
        total++;
        if (mot_err !== 5'b00000) begin
            bad++;
            $display("FAIL held_cleared got=%b exp=00000", mot_err);
        end
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        sens_raw_n = 3'b011;
        repeat (7) tick();
        total++;
        if (fail_sens_n !== 3'b011) begin
            bad++;
            $display("FAIL mid_pre_sens got=%b exp=011", fail_sens_n);
        end
        sens_raw_n = 3'b111;
        mot_raw    = 5'b11111;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        total++;
        if (mot_err !== 5'b00000 || fail_sens_n !== 3'b111) begin
            bad++;
            $display("FAIL mid_rst_outputs got=%b/%b exp=00000/111", mot_err, fail_sens_n);
        end
        total++;
        if (fault_any !== 1'b0 || fault_new !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst_flags got=%b%b exp=00", fault_any, fault_new);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) tick();
        total++;
        if (mot_err !== 5'b00000) begin
            bad++;
            $display("FAIL mid_lat_early got=%b exp=00000", mot_err);
        end
        tick();
        total++;
        if (mot_err !== 5'b11111 || fail_sens_n !== 3'b111) begin
            bad++;
            $display("FAIL mid_lat_exact got=%b/%b exp=11111/111", mot_err, fail_sens_n);
        end
        tick();
        total++;
        if (fault_any !== 1'b1 || fault_new !== 1'b1) begin
            bad++;
            $display("FAIL mid_flags got=%b%b exp=11", fault_any, fault_new);
        end
        tick();
        total++;
        if (fault_new !== 1'b0) begin
            bad++;
            $display("FAIL mid_new_single got=%b exp=0", fault_new);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_mot_latency();
        test_glitch();
        test_sens_latch();
        test_clr_while_held();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
